// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: constants and FSM state type shared by decode, regfile and the issue controller
package regfile_scoreboard_pkg;
   localparam int REGNUM = 16;
   localparam int ADDRESSWIDTH = 4;
   localparam int PCREG = 15;
   localparam int CNTWIDTH = 2;
   typedef enum logic [1:0] {RUN, BRANCH_WAIT, FLUSH} state_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback/pipeline-control bundle between decode (master) and the issue controller (slave)
// master drives the decoded fields and the writeback retire; slave returns stall/issue/flush, pendingMask and error
interface regfile_scoreboard_if;
   import regfile_scoreboard_pkg::*;
   logic decodeValid;
   logic [ADDRESSWIDTH-1:0] reg1FinalAddress;
   logic [ADDRESSWIDTH-1:0] reg2Address;
   logic [ADDRESSWIDTH-1:0] regDestinationAddress;
   logic usesReg1;
   logic usesReg2;
   logic writesDest;
   logic obtainPCAsR1;
   logic writeEnable;
   logic [ADDRESSWIDTH-1:0] writeAddress;
   logic stall;
   logic issue;
   logic flush;
   logic [REGNUM-1:0] pendingMask;
   logic error;
   modport master (
      output decodeValid, reg1FinalAddress, reg2Address, regDestinationAddress,
      output usesReg1, usesReg2, writesDest, obtainPCAsR1, writeEnable, writeAddress,
      input stall, issue, flush, pendingMask, error
   );
   modport slave (
      input decodeValid, reg1FinalAddress, reg2Address, regDestinationAddress,
      input usesReg1, usesReg2, writesDest, obtainPCAsR1, writeEnable, writeAddress,
      output stall, issue, flush, pendingMask, error
   );
endinterface

// File: rtl/regfile_scoreboard_counter.sv
// scoreboard_counter: pending-write counter for one register
// ports: clock; clear (sync); inc (issue of a write); dec (retire); count; nonzero; underflow (retire seen at zero)
module scoreboard_counter
   import regfile_scoreboard_pkg::*;
(
   input  logic                clock,
   input  logic                clear,
   input  logic                inc,
   input  logic                dec,
   output logic [CNTWIDTH-1:0] count,
   output logic                nonzero,
   output logic                underflow
);
   logic up, down;
   assign nonzero = |count;
   assign underflow = dec & ~nonzero;
   // a retire only counts against a nonzero counter; inc and a counted retire cancel
   assign up = inc & ~(dec & nonzero) & ~&count;
   assign down = dec & nonzero & ~inc;
   always_ff @(posedge clock)
      if (clear) count <= '0;
      else if (up) count <= count + 1'b1;
      else if (down) count <= count - 1'b1;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: decode issue controller with per-register write scoreboard and branch wait/flush sequencing
// ports: clock, reset (sync, active-high); bus (slave): decode fields and writeback in, stall/issue/flush/pendingMask/error out
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
(
   input logic clock,
   input logic reset,
   regfile_scoreboard_if.slave bus
);
   logic [CNTWIDTH-1:0] cnt [REGNUM];
   logic [REGNUM-1:0] nz, uf;
   logic err, hazard;
   state_t state, state_nx;
   genvar i;
   generate
      for (i = 0; i < REGNUM; i++) begin : g_cnt
         scoreboard_counter u_cnt (
            .clock     (clock),
            .clear     (reset),
            .inc       (bus.issue & bus.writesDest & (bus.regDestinationAddress == ADDRESSWIDTH'(i))),
            .dec       (bus.writeEnable & (bus.writeAddress == ADDRESSWIDTH'(i))),
            .count     (cnt[i]),
            .nonzero   (nz[i]),
            .underflow (uf[i])
         );
      end
   endgenerate
   // no writeback bypass: hazards look only at registered counters
   assign hazard = (state == RUN) &
                   ((bus.usesReg1 & ~bus.obtainPCAsR1 & nz[bus.reg1FinalAddress]) |
                    (bus.usesReg2 & nz[bus.reg2Address]) |
                    (bus.writesDest & (&cnt[bus.regDestinationAddress])));
   assign bus.stall = bus.decodeValid & (hazard | (state != RUN));
   assign bus.issue = bus.decodeValid & ~bus.stall;
   assign bus.flush = state == FLUSH;
   assign bus.pendingMask = nz;
   assign bus.error = err;
   // leave BRANCH_WAIT only on the retire of the last outstanding PC write
   always_comb
      state_nx = (state == RUN && bus.issue && bus.writesDest &&
                  bus.regDestinationAddress == ADDRESSWIDTH'(PCREG)) ? BRANCH_WAIT :
                 (state == BRANCH_WAIT && bus.writeEnable &&
                  bus.writeAddress == ADDRESSWIDTH'(PCREG) && cnt[PCREG] == CNTWIDTH'(1)) ? FLUSH :
                 (state == FLUSH) ? RUN : state;
   always_ff @(posedge clock)
      if (reset) begin
         state <= RUN;
         err <= 1'b0;
      end else begin
         state <= state_nx;
         err <= err | (|uf);
      end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors with hand-computed expectations for regfile_scoreboard
module tb_regfile_scoreboard;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   regfile_scoreboard_if bus ();
   regfile_scoreboard dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic drv(input logic v, input logic [3:0] r1, input logic u1, input logic pc,
                      input logic [3:0] r2, input logic u2, input logic [3:0] d, input logic w);
      bus.decodeValid = v;
      bus.reg1FinalAddress = r1;
      bus.usesReg1 = u1;
      bus.obtainPCAsR1 = pc;
      bus.reg2Address = r2;
      bus.usesReg2 = u2;
      bus.regDestinationAddress = d;
      bus.writesDest = w;
   endtask
   task automatic wbk(input logic en, input logic [3:0] a);
      bus.writeEnable = en;
      bus.writeAddress = a;
   endtask
   task automatic outs(input string tag, input logic s, input logic i, input logic f);
      #1;
      chk({tag, ".stall"}, 32'(bus.stall), 32'(s));
      chk({tag, ".issue"}, 32'(bus.issue), 32'(i));
      chk({tag, ".flush"}, 32'(bus.flush), 32'(f));
   endtask
   initial begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      wbk(0, 0);
      tick();
      tick();
      reset = 1'b0;
      outs("rst", 0, 0, 0);
      chk("rst.mask", 32'(bus.pendingMask), 0);
      chk("rst.err", 32'(bus.error), 0);
      // RAW on r3
      drv(1, 0, 0, 0, 0, 0, 3, 1);
      outs("raw.wr3", 0, 1, 0);
      tick();
      drv(1, 3, 1, 0, 0, 0, 0, 0);
      outs("raw.rd3", 1, 0, 0);
      chk("raw.mask1", 32'(bus.pendingMask), 32'h0008);
      tick();
      wbk(1, 3);
      outs("raw.retire_nobypass", 1, 0, 0);
      tick();
      wbk(0, 0);
      outs("raw.after", 0, 1, 0);
      chk("raw.mask0", 32'(bus.pendingMask), 0);
      // source 2 hazard and PC-as-source-1 exemption
      drv(1, 0, 0, 0, 0, 0, 6, 1);
      tick();
      drv(1, 0, 0, 0, 6, 1, 0, 0);
      outs("raw.src2", 1, 0, 0);
      drv(1, 6, 1, 1, 0, 0, 0, 0);
      outs("raw.pcexempt", 0, 1, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      wbk(1, 6);
      tick();
      wbk(0, 0);
      chk("raw.mask6", 32'(bus.pendingMask), 0);
      // WAW overflow on r5
      for (int k = 0; k < 3; k++) begin
         drv(1, 0, 0, 0, 0, 0, 5, 1);
         outs($sformatf("waw.w%0d", k), 0, 1, 0);
         tick();
      end
      outs("waw.fourth", 1, 0, 0);
      chk("waw.mask", 32'(bus.pendingMask), 32'h0020);
      wbk(1, 5);
      outs("waw.retire_cycle", 1, 0, 0);
      tick();
      wbk(0, 0);
      outs("waw.fourth_issues", 0, 1, 0);
      tick();
      outs("waw.full_again", 1, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         wbk(1, 5);
         tick();
      end
      wbk(0, 0);
      chk("waw.drained", 32'(bus.pendingMask), 0);
      chk("waw.err", 32'(bus.error), 0);
      // simultaneous issue and retire on r7
      drv(1, 0, 0, 0, 0, 0, 7, 1);
      tick();
      wbk(1, 7);
      outs("same.issue", 0, 1, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      wbk(0, 0);
      chk("same.mask", 32'(bus.pendingMask), 32'h0080);
      chk("same.err", 32'(bus.error), 0);
      wbk(1, 7);
      tick();
      wbk(0, 0);
      chk("same.one_retire", 32'(bus.pendingMask), 0);
      chk("same.err2", 32'(bus.error), 0);
      // branch through r15
      drv(1, 0, 0, 0, 0, 0, 15, 1);
      outs("br.issue", 0, 1, 0);
      tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      outs("br.wait1", 1, 0, 0);
      tick();
      outs("br.wait2", 1, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      outs("br.novalid", 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      wbk(1, 15);
      outs("br.retire", 1, 0, 0);
      tick();
      wbk(0, 0);
      outs("br.flush", 1, 0, 1);
      chk("br.mask", 32'(bus.pendingMask), 0);
      tick();
      outs("br.resume", 0, 1, 0);
      // retire at zero sets sticky error
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      wbk(1, 9);
      tick();
      wbk(0, 0);
      chk("err.set", 32'(bus.error), 1);
      chk("err.mask", 32'(bus.pendingMask), 0);
      drv(1, 0, 0, 0, 0, 0, 2, 1);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      wbk(1, 2);
      tick();
      wbk(0, 0);
      chk("err.sticky", 32'(bus.error), 1);
      chk("err.mask2", 32'(bus.pendingMask), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("err.reset", 32'(bus.error), 0);
      // reset during BRANCH_WAIT
      drv(1, 0, 0, 0, 0, 0, 4, 1);
      tick();
      drv(1, 0, 0, 0, 0, 0, 15, 1);
      outs("mid.br_issue", 0, 1, 0);
      tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      outs("mid.wait", 1, 0, 0);
      chk("mid.mask", 32'(bus.pendingMask), 32'h8010);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      outs("mid.after", 0, 1, 0);
      chk("mid.mask0", 32'(bus.pendingMask), 0);
      chk("mid.err", 32'(bus.error), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Issue controller for the decode stage and register file. Tracks in-flight register writes in a per-register scoreboard. Stalls decode on read-after-write and write-after-write-overflow hazards. Sequences PC-writing (branch) instructions through a wait/flush state machine, so decode never issues past an unresolved PC update. Sits beside the decode module: it consumes its decoded addresses and the writeback port, and gates the fetch/decode pipeline registers.

## Interface
- REGNUM, 16, number of architectural registers
- ADDRESSWIDTH, 4, register address width
- PCREG, 15, register index aliased to the PC
- CNTWIDTH, 2, width of each per-register pending-write counter
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- decodeValid  input  1  decode holds a valid instruction this cycle
- reg1FinalAddress  input  ADDRESSWIDTH  source 1 address after PC-select mux
- reg2Address  input  ADDRESSWIDTH  source 2 address
- regDestinationAddress  input  ADDRESSWIDTH  destination address
- usesReg1, usesReg2, writesDest  input  1  per-field use flags from control
- obtainPCAsR1  input  1  source 1 is the PC; exempt from the source-1 hazard check
- writeEnable  input  1  writeback retires a register write this cycle
- writeAddress  input  ADDRESSWIDTH  register being retired
- stall  output  1  hold fetch/decode registers
- issue  output  1  instruction advances to execute (decodeValid & ~stall)
- flush  output  1  one-cycle squash of the fetch/decode registers
- pendingMask  output  REGNUM  bit i set when counter[i] != 0
- error  output  1  sticky: retire seen with counter at zero

## Operation
- Scoreboard: one CNTWIDTH-bit counter per register, all 0 after reset.
- Counter update per clock, for each register r:
  - +1 if issue & writesDest & regDestinationAddress==r.
  - -1 if writeEnable & writeAddress==r & counter!=0.
  - Both conditions in the same cycle: unchanged.
- Retire when counter==0: counter stays 0 and error is set. Error clears only on reset.
- Hazard (combinational, RUN state only):
  - Source 1: usesReg1 & ~obtainPCAsR1 & counter[reg1FinalAddress]!=0.
  - Source 2: usesReg2 & counter[reg2Address]!=0.
  - Overflow: writesDest & counter[regDestinationAddress]==2^CNTWIDTH-1.
- No writeback bypass: a retire clears a hazard one cycle later, not in the same cycle.
- stall = decodeValid & (hazard | state!=RUN).
- FSM states:
  - RUN: issue of an instruction with writesDest & regDestinationAddress==PCREG -> BRANCH_WAIT; else stay.
  - BRANCH_WAIT: stall asserted whenever decodeValid. Leave when writeEnable & writeAddress==PCREG & counter[PCREG]==1 -> FLUSH.
  - FLUSH: flush=1, stall=decodeValid, -> RUN unconditionally.
- Reset at any point: state RUN, all counters 0, error 0; any in-flight writes are forgotten.

## Timing
- Reset values: stall 0, issue 0, flush 0, pendingMask 0, error 0; state RUN.
- stall and issue are combinational from current inputs and registered state: same-cycle response to decode.
- Counters, FSM and error are registered; effects are visible the cycle after the triggering edge.
- flush is exactly one cycle, starting the cycle after the PCREG retire edge.
- The branch penalty is the execute-to-writeback depth plus one flush cycle.
- decodeValid=0: stall=0 and issue=0; the FSM still advances on writeback.

## Structure
- Shared package: PCREG constant, FSM state enum (RUN, BRANCH_WAIT, FLUSH), CNTWIDTH default. The decode and regfile modules use the same package constants.
- One sub-module, scoreboard_counter, instantiated REGNUM times in a generate loop: inc/dec/clear inputs, count and nonzero outputs, saturation handling local.
- FSM and hazard logic stay in the top module.

## Test plan
- Reset, then issue write to r3 and read r3 next cycle -> stall=1 until the cycle after writeEnable/writeAddress=3, then issue=1; pendingMask bit 3 goes 1 then 0.
- Issue three writes to r5 back-to-back -> fourth write to r5 stalls (counter 3). One retire of r5 -> fourth issues the following cycle, counter returns to 3.
- Issue and retire r7 in the same cycle with counter[7]=1 -> counter[7] stays 1, no error.
- Issue write to r15, then decodeValid held -> stall=1 in BRANCH_WAIT. Retire r15 -> flush=1 for one cycle, then RUN and issue resumes.
- Retire r9 with counter 0 -> error=1 and stays 1 across later traffic. Reset -> error=0.
- Assert reset mid-BRANCH_WAIT with counters nonzero -> next cycle state RUN, pendingMask=0, stall=0 with decodeValid=1 and no hazard.
